// File: rtl/pipe_ctrl_hazard.sv
// Control-path pipeline: carries the decoder bundle through ID/EX, EX/MEM and
// MEM/WB, detects load-use, taken-branch and jump hazards, drives PC / IF/ID
// enables and flush, and counts inserted bubbles with a saturating counter.
module pipe_ctrl_hazard #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic             id_regwrite_i,
  input  logic             id_alusrc_i,
  input  logic             id_regdst_i,
  input  logic             id_jump_i,
  input  logic             id_branch_i,
  input  logic             id_branchtype_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic             id_memtoreg_i,
  input  logic [2:0]       id_aluop_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             ex_zero_i,
  output logic [2:0]       ex_aluop_o,
  output logic             ex_alusrc_o,
  output logic             ex_branch_o,
  output logic [RA_W-1:0]  ex_rs_o,
  output logic [RA_W-1:0]  ex_rt_o,
  output logic [RA_W-1:0]  ex_wreg_o,
  output logic             mem_regwrite_o,
  output logic             mem_memread_o,
  output logic             mem_memwrite_o,
  output logic             mem_memtoreg_o,
  output logic [RA_W-1:0]  mem_wreg_o,
  output logic             wb_regwrite_o,
  output logic             wb_memtoreg_o,
  output logic [RA_W-1:0]  wb_wreg_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             branch_taken_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  // ID/EX controls that have no ex_* output of their own
  logic ex_regwrite;
  logic ex_memread;
  logic ex_memwrite;
  logic ex_memtoreg;
  logic ex_branchtype;

  logic            rt_used;
  logic            lu;
  logic            load_bubble;
  logic            count_bubble;
  logic [RA_W-1:0] id_wreg;

  assign id_wreg = id_regdst_i ? id_rd_i : id_rt_i;

  // Hazard detection and priority resolution; purely combinational
  always_comb begin
    rt_used        = ~id_alusrc_i | id_memwrite_i;
    branch_taken_o = ex_branch_o & (ex_zero_i ^ ex_branchtype);
    lu             = id_valid_i & ~id_jump_i & ex_memread & (ex_wreg_o != '0) &
                     ((ex_wreg_o == id_rs_i) | ((ex_wreg_o == id_rt_i) & rt_used));
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    load_bubble    = ~id_valid_i;  // empty slot: bubble, but not a hazard
    count_bubble   = 1'b0;
    if (branch_taken_o) begin
      ifid_flush_o = 1'b1;
      load_bubble  = 1'b1;
      count_bubble = 1'b1;
    end else if (lu) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      load_bubble  = 1'b1;
      count_bubble = 1'b1;
    end else if (id_jump_i && id_valid_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  // ID/EX register: accept the decoder bundle or load an all-zero bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || load_bubble) begin
      ex_regwrite   <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_memtoreg   <= 1'b0;
      ex_branchtype <= 1'b0;
      ex_alusrc_o   <= 1'b0;
      ex_branch_o   <= 1'b0;
      ex_aluop_o    <= '0;
      ex_rs_o       <= '0;
      ex_rt_o       <= '0;
      ex_wreg_o     <= '0;
    end else begin
      ex_regwrite   <= id_regwrite_i;
      ex_memread    <= id_memread_i;
      ex_memwrite   <= id_memwrite_i;
      ex_memtoreg   <= id_memtoreg_i;
      ex_branchtype <= id_branchtype_i;
      ex_alusrc_o   <= id_alusrc_i;
      ex_branch_o   <= id_branch_i;
      ex_aluop_o    <= id_aluop_i;
      ex_rs_o       <= id_rs_i;
      ex_rt_o       <= id_rt_i;
      ex_wreg_o     <= id_wreg;
    end
  end

  // EX/MEM register: always advances
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_regwrite_o <= 1'b0;
      mem_memread_o  <= 1'b0;
      mem_memwrite_o <= 1'b0;
      mem_memtoreg_o <= 1'b0;
      mem_wreg_o     <= '0;
    end else begin
      mem_regwrite_o <= ex_regwrite;
      mem_memread_o  <= ex_memread;
      mem_memwrite_o <= ex_memwrite;
      mem_memtoreg_o <= ex_memtoreg;
      mem_wreg_o     <= ex_wreg_o;
    end
  end

  // MEM/WB register: always advances
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_regwrite_o <= 1'b0;
      wb_memtoreg_o <= 1'b0;
      wb_wreg_o     <= '0;
    end else begin
      wb_regwrite_o <= mem_regwrite_o;
      wb_memtoreg_o <= mem_memtoreg_o;
      wb_wreg_o     <= mem_wreg_o;
    end
  end

  // Saturating count of hazard bubbles (empty ID slots are not counted)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (count_bubble && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Directed bench for pipe_ctrl_hazard: pipeline flow, load-use stall,
// taken/not-taken branches, jump, priority, saturation and async reset.
module tb_pipe_ctrl_hazard;

  localparam int RA_W = 5;

  logic clk_i = 1'b0;
  logic rst_i;
  logic id_valid_i, id_regwrite_i, id_alusrc_i, id_regdst_i, id_jump_i;
  logic id_branch_i, id_branchtype_i, id_memread_i, id_memwrite_i, id_memtoreg_i;
  logic [2:0] id_aluop_i;
  logic [RA_W-1:0] id_rs_i, id_rt_i, id_rd_i;
  logic ex_zero_i;

  logic [2:0] ex_aluop_o;
  logic ex_alusrc_o, ex_branch_o;
  logic [RA_W-1:0] ex_rs_o, ex_rt_o, ex_wreg_o;
  logic mem_regwrite_o, mem_memread_o, mem_memwrite_o, mem_memtoreg_o;
  logic [RA_W-1:0] mem_wreg_o;
  logic wb_regwrite_o, wb_memtoreg_o;
  logic [RA_W-1:0] wb_wreg_o;
  logic pc_write_o, ifid_write_o, ifid_flush_o, branch_taken_o;
  logic [15:0] bubble_cnt_o;

  // Narrow-counter instance driven by the same stimulus (saturation check)
  logic [2:0] s_ex_aluop;
  logic s_ex_alusrc, s_ex_branch;
  logic [RA_W-1:0] s_ex_rs, s_ex_rt, s_ex_wreg;
  logic s_mem_regwrite, s_mem_memread, s_mem_memwrite, s_mem_memtoreg;
  logic [RA_W-1:0] s_mem_wreg;
  logic s_wb_regwrite, s_wb_memtoreg;
  logic [RA_W-1:0] s_wb_wreg;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_branch_taken;
  logic [1:0] s_bubble_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  pipe_ctrl_hazard #(.RA_W(RA_W), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_regwrite_i(id_regwrite_i), .id_alusrc_i(id_alusrc_i),
    .id_regdst_i(id_regdst_i), .id_jump_i(id_jump_i), .id_branch_i(id_branch_i),
    .id_branchtype_i(id_branchtype_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .id_aluop_i(id_aluop_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_zero_i(ex_zero_i),
    .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o), .ex_branch_o(ex_branch_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_wreg_o(ex_wreg_o),
    .mem_regwrite_o(mem_regwrite_o), .mem_memread_o(mem_memread_o),
    .mem_memwrite_o(mem_memwrite_o), .mem_memtoreg_o(mem_memtoreg_o),
    .mem_wreg_o(mem_wreg_o),
    .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o), .wb_wreg_o(wb_wreg_o),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .branch_taken_o(branch_taken_o), .bubble_cnt_o(bubble_cnt_o)
  );

  pipe_ctrl_hazard #(.RA_W(RA_W), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_regwrite_i(id_regwrite_i), .id_alusrc_i(id_alusrc_i),
    .id_regdst_i(id_regdst_i), .id_jump_i(id_jump_i), .id_branch_i(id_branch_i),
    .id_branchtype_i(id_branchtype_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .id_aluop_i(id_aluop_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .ex_zero_i(ex_zero_i),
    .ex_aluop_o(s_ex_aluop), .ex_alusrc_o(s_ex_alusrc), .ex_branch_o(s_ex_branch),
    .ex_rs_o(s_ex_rs), .ex_rt_o(s_ex_rt), .ex_wreg_o(s_ex_wreg),
    .mem_regwrite_o(s_mem_regwrite), .mem_memread_o(s_mem_memread),
    .mem_memwrite_o(s_mem_memwrite), .mem_memtoreg_o(s_mem_memtoreg),
    .mem_wreg_o(s_mem_wreg),
    .wb_regwrite_o(s_wb_regwrite), .wb_memtoreg_o(s_wb_memtoreg), .wb_wreg_o(s_wb_wreg),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
    .branch_taken_o(s_branch_taken), .bubble_cnt_o(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    id_valid_i = 0; id_regwrite_i = 0; id_alusrc_i = 0; id_regdst_i = 0;
    id_jump_i = 0; id_branch_i = 0; id_branchtype_i = 0; id_memread_i = 0;
    id_memwrite_i = 0; id_memtoreg_i = 0; id_aluop_i = 3'b000;
    id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
  endtask

  task automatic set_rtype(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                           input logic [RA_W-1:0] rd);
    set_idle();
    id_valid_i = 1; id_regwrite_i = 1; id_regdst_i = 1; id_aluop_i = 3'b010;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
  endtask

  task automatic set_lw(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt);
    set_idle();
    id_valid_i = 1; id_regwrite_i = 1; id_alusrc_i = 1; id_memread_i = 1;
    id_memtoreg_i = 1; id_aluop_i = 3'b000; id_rs_i = rs; id_rt_i = rt;
  endtask

  task automatic set_branch(input logic bt);
    set_idle();
    id_valid_i = 1; id_branch_i = 1; id_branchtype_i = bt; id_aluop_i = 3'b001;
    id_rs_i = 5'd1; id_rt_i = 5'd2;
  endtask

  task automatic set_jump();
    set_idle();
    id_valid_i = 1; id_jump_i = 1; id_aluop_i = 3'b011;
    id_rs_i = 5'd5; id_rt_i = 5'd5;
  endtask

  initial begin
    rst_i = 1; ex_zero_i = 0;
    set_idle();

    // Reset state
    #3;
    check("rst_ex_aluop", ex_aluop_o, 0);
    check("rst_ex_wreg", ex_wreg_o, 0);
    check("rst_mem_regwrite", mem_regwrite_o, 0);
    check("rst_wb_wreg", wb_wreg_o, 0);
    check("rst_pc_write", pc_write_o, 1);
    check("rst_ifid_write", ifid_write_o, 1);
    check("rst_flush", ifid_flush_o, 0);
    check("rst_taken", branch_taken_o, 0);
    check("rst_cnt", bubble_cnt_o, 0);
    @(negedge clk_i); rst_i = 0;
    $display("txn reset released");

    // R-type flow: add rd=3
    step(); set_rtype(5'd1, 5'd2, 5'd3);
    @(negedge clk_i);
    check("rt_pc_write", pc_write_o, 1);
    check("rt_flush", ifid_flush_o, 0);
    step(); set_idle();
    @(negedge clk_i);
    check("rt_ex_wreg", ex_wreg_o, 3);
    check("rt_ex_aluop", ex_aluop_o, 3'b010);
    step(); @(negedge clk_i);
    check("rt_mem_regwrite", mem_regwrite_o, 1);
    check("rt_mem_wreg", mem_wreg_o, 3);
    check("rt_ex_bubble", ex_aluop_o, 0);
    step(); @(negedge clk_i);
    check("rt_wb_wreg", wb_wreg_o, 3);
    check("rt_wb_regwrite", wb_regwrite_o, 1);
    $display("txn rtype add rd=3");

    // Load-use: lw rt=2 then add rs=2
    step(); set_lw(5'd1, 5'd2);
    @(negedge clk_i);
    check("lu_c0_pc_write", pc_write_o, 1);
    step(); set_rtype(5'd2, 5'd4, 5'd6);
    @(negedge clk_i);
    check("lu_c1_pc_write", pc_write_o, 0);
    check("lu_c1_ifid_write", ifid_write_o, 0);
    check("lu_c1_flush", ifid_flush_o, 0);
    exp_cnt++;
    step(); @(negedge clk_i);
    check("lu_c2_ex_aluop", ex_aluop_o, 0);
    check("lu_c2_ex_alusrc", ex_alusrc_o, 0);
    check("lu_c2_ex_wreg", ex_wreg_o, 0);
    check("lu_c2_cnt", bubble_cnt_o, exp_cnt);
    check("lu_c2_pc_write", pc_write_o, 1);
    check("lu_c2_mem_memread", mem_memread_o, 1);
    step(); set_idle();
    @(negedge clk_i);
    check("lu_c3_ex_wreg", ex_wreg_o, 6);
    check("lu_c3_ex_aluop", ex_aluop_o, 3'b010);
    check("lu_c3_ex_rs", ex_rs_o, 2);
    $display("txn load-use lw r2 / add r2");

    // Load to r0: no stall
    step(); set_lw(5'd1, 5'd0);
    step(); set_rtype(5'd0, 5'd4, 5'd6);
    @(negedge clk_i);
    check("lu0_pc_write", pc_write_o, 1);
    check("lu0_ifid_write", ifid_write_o, 1);
    step(); set_idle();
    @(negedge clk_i);
    check("lu0_ex_wreg", ex_wreg_o, 6);
    check("lu0_cnt", bubble_cnt_o, exp_cnt);
    $display("txn load r0 no stall");

    // Taken bne (zero=0)
    step(); set_branch(1'b1);
    step(); set_rtype(5'd3, 5'd4, 5'd5); ex_zero_i = 0;
    @(negedge clk_i);
    check("bne_taken", branch_taken_o, 1);
    check("bne_flush", ifid_flush_o, 1);
    check("bne_pc_write", pc_write_o, 1);
    exp_cnt++;
    step(); set_idle();
    @(negedge clk_i);
    check("bne_ex_bubble_aluop", ex_aluop_o, 0);
    check("bne_ex_bubble_wreg", ex_wreg_o, 0);
    check("bne_cnt", bubble_cnt_o, exp_cnt);
    $display("txn bne taken");

    // Not-taken bne (zero=1)
    step(); set_branch(1'b1);
    step(); set_rtype(5'd3, 5'd4, 5'd5); ex_zero_i = 1;
    @(negedge clk_i);
    check("bnent_taken", branch_taken_o, 0);
    check("bnent_flush", ifid_flush_o, 0);
    step(); set_idle(); ex_zero_i = 0;
    @(negedge clk_i);
    check("bnent_ex_wreg", ex_wreg_o, 5);
    check("bnent_cnt", bubble_cnt_o, exp_cnt);
    $display("txn bne not taken");

    // Jump in ID with lw r5 in EX
    step(); set_lw(5'd1, 5'd5);
    step(); set_jump();
    @(negedge clk_i);
    check("j_flush", ifid_flush_o, 1);
    check("j_pc_write", pc_write_o, 1);
    check("j_ifid_write", ifid_write_o, 1);
    step(); set_idle();
    @(negedge clk_i);
    check("j_ex_aluop", ex_aluop_o, 3'b011);
    check("j_cnt", bubble_cnt_o, exp_cnt);
    $display("txn jump over load");

    // Priority: EX bundle is both a taken beq and a load to r2; ID uses r2
    step(); set_idle();
    id_valid_i = 1; id_branch_i = 1; id_branchtype_i = 0; id_memread_i = 1;
    id_aluop_i = 3'b001; id_rt_i = 5'd2;
    step(); set_rtype(5'd2, 5'd4, 5'd6); ex_zero_i = 1;
    @(negedge clk_i);
    check("pri_pc_write", pc_write_o, 1);
    check("pri_ifid_write", ifid_write_o, 1);
    check("pri_flush", ifid_flush_o, 1);
    exp_cnt++;
    step(); set_idle(); ex_zero_i = 0;
    @(negedge clk_i);
    check("pri_cnt", bubble_cnt_o, exp_cnt);
    check("sat_cnt_at3", s_bubble_cnt, 3);
    $display("txn branch+loaduse priority");

    // Two more taken beq bubbles: wide counter 5, narrow counter held at 3
    for (int i = 0; i < 2; i++) begin
      step(); set_branch(1'b0);
      step(); set_idle(); ex_zero_i = 1;
      exp_cnt++;
    end
    step(); ex_zero_i = 0;
    @(negedge clk_i);
    check("sat_wide_cnt", bubble_cnt_o, exp_cnt);
    check("sat_narrow_cnt", s_bubble_cnt, 3);
    $display("txn saturation bubbles=%0d", exp_cnt);

    // Reset asserted mid-stall
    step(); set_lw(5'd1, 5'd2);
    step(); set_rtype(5'd2, 5'd0, 5'd7);
    @(negedge clk_i);
    check("rs_stall_pc_write", pc_write_o, 0);
    #1 rst_i = 1;
    #1;
    check("rs_pc_write", pc_write_o, 1);
    check("rs_ifid_write", ifid_write_o, 1);
    check("rs_ex_wreg", ex_wreg_o, 0);
    check("rs_mem_memread", mem_memread_o, 0);
    check("rs_mem_wreg", mem_wreg_o, 0);
    check("rs_wb_regwrite", wb_regwrite_o, 0);
    check("rs_cnt", bubble_cnt_o, 0);
    check("rs_sat_cnt", s_bubble_cnt, 0);
    @(negedge clk_i); rst_i = 0;
    #1;
    check("rs_post_pc_write", pc_write_o, 1);
    check("rs_post_taken", branch_taken_o, 0);
    step(); @(negedge clk_i);
    check("rs_post_ex_wreg", ex_wreg_o, 7);
    check("rs_post_cnt", bubble_cnt_o, 0);
    $display("txn reset mid-stall");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_hazard.md
# pipe_ctrl_hazard

Control-path pipeline for the 5-stage CPU. Consumes the ID-stage control bundle produced by the instruction decoder, carries it through the ID/EX, EX/MEM and MEM/WB control registers, and detects load-use, branch and jump hazards. It drives the PC and IF/ID write-enable and flush controls, inserts bubbles into ID/EX, and counts inserted bubbles for performance debug.

## Interface
- RA_W, default 5: register-address width.
- CNT_W, default 16: bubble-counter width.

- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- id_valid_i, in, 1: IF/ID holds a valid instruction.
- id_regwrite_i, id_alusrc_i, id_regdst_i, id_jump_i, id_branch_i, id_branchtype_i, id_memread_i, id_memwrite_i, id_memtoreg_i, in, 1 each: decoder controls.
- id_aluop_i, in, 3: decoder ALUOp.
- id_rs_i, id_rt_i, id_rd_i, in, RA_W: register fields of the ID instruction.
- ex_zero_i, in, 1: ALU zero flag of the EX instruction.
- ex_aluop_o, out, 3; ex_alusrc_o, ex_branch_o, out, 1 each: ID/EX controls.
- ex_rs_o, ex_rt_o, ex_wreg_o, out, RA_W: ID/EX register fields (for the forwarding unit).
- mem_regwrite_o, mem_memread_o, mem_memwrite_o, mem_memtoreg_o, out, 1 each; mem_wreg_o, out, RA_W: EX/MEM controls.
- wb_regwrite_o, wb_memtoreg_o, out, 1 each; wb_wreg_o, out, RA_W: MEM/WB controls.
- pc_write_o, ifid_write_o, ifid_flush_o, branch_taken_o, out, 1 each: hazard controls (combinational).
- bubble_cnt_o, out, CNT_W: saturating bubble count.

## Operation
- Write register selected at ID: `wreg = id_regdst_i ? id_rd_i : id_rt_i`. Stored in ID/EX, then moves to EX/MEM and MEM/WB.
- ID/EX also holds `regwrite`, `memread`, `memwrite`, `memtoreg` and `branchtype`. These are internal where no `ex_*` output exists.
- Branch resolution in EX: `branch_taken_o = ex_branch & (ex_zero_i ^ ex_branchtype)`. beq is branchtype 0; bne is branchtype 1.
- The ID instruction uses rt when `id_alusrc_i == 0` or `id_memwrite_i == 1`. It always uses rs.
- Load-use hazard `lu` is asserted when all of the following hold:
  - `id_valid_i`
  - `!id_jump_i`
  - `ex_memread`
  - `ex_wreg_o != 0`
  - `ex_wreg_o == id_rs_i`, or (`ex_wreg_o == id_rt_i` and rt is used).
- Priority, highest first:
  1. branch_taken: `ifid_flush_o = 1`, `pc_write_o = 1`, `ifid_write_o = 1`, and a bubble is loaded into ID/EX. `lu` is ignored.
  2. lu: `pc_write_o = 0`, `ifid_write_o = 0`, `ifid_flush_o = 0`, and a bubble is loaded into ID/EX.
  3. id_jump_i && id_valid_i: `ifid_flush_o = 1`, PC and IF/ID writes enabled, and the jump control bundle enters ID/EX normally.
  4. Otherwise: PC and IF/ID writes enabled, no flush.
- Bubble means every ID/EX control bit is 0 and `ex_aluop_o = 0`. RA fields are don't-care but are driven 0.
- `id_valid_i = 0` loads a bubble. This does not count and raises no hazard.
- EX/MEM and MEM/WB always advance. They are never stalled.
- `bubble_cnt_o` increments by 1 in each cycle where rule 1 or rule 2 fires. It saturates at all-ones.

## Timing
- Reset (async, immediate) clears all pipeline registers and `bubble_cnt_o` to 0. All `ex_*`, `mem_*` and `wb_*` outputs read 0.
- After reset: `pc_write_o = 1`, `ifid_write_o = 1`, `ifid_flush_o = 0`, `branch_taken_o = 0`.
- Latency: a bundle presented at ID in cycle N appears on `ex_*` in N+1, on `mem_*` in N+2 and on `wb_*` in N+3.
- Hazard outputs are combinational from the current ID inputs, the ID/EX state and `ex_zero_i`. They are valid in the same cycle.
- A load-use stall lasts exactly 1 cycle, because the bubble clears `ex_memread`.
- Taken branch costs 2 squashed instructions: the IF/ID instruction and the ID instruction. Jump costs 1.
- Reset asserted mid-stall: all state clears at once. The first post-reset cycle has no hazard.

## Test plan
- **Reset:** assert `rst_i` mid-clock with nonzero state. Required: all registered outputs 0 before the next edge, `pc_write_o = 1`, `bubble_cnt_o = 0`.
- **R-type flow:** add with rd=3, `id_regwrite_i = 1`, `id_regdst_i = 1` at cycle 0. Required: `ex_wreg_o = 3` at cycle 1, `mem_regwrite_o = 1` at cycle 2, `wb_wreg_o = 3` with `wb_regwrite_o = 1` at cycle 3.
- **Load-use:** lw rt=2, then add rs=2. Required:
  - Cycle 1: `pc_write_o = 0`, `ifid_write_o = 0`.
  - Cycle 2: `ex_*` controls all 0, `bubble_cnt_o = 1`.
  - Cycle 3: add's bundle on `ex_*`.
  - A repeat with rt=0 as the load target produces no stall.
- **Taken bne:** bne in EX with `ex_zero_i = 0`. Required: `branch_taken_o = 1`, `ifid_flush_o = 1`, bubble in ID/EX next cycle, counter +1. With `ex_zero_i = 1`, no flush.
- **Jump:** jump in ID with an lw in EX writing rt=5. Required: `ifid_flush_o = 1`, no stall, jump bundle (ALUOp 011) on `ex_aluop_o` next cycle, counter unchanged.
- **Priority and saturation:**
  - Taken branch and load-use in the same cycle: required `pc_write_o = 1`, flush, counter +1 only.
  - Preload the counter with CNT_W=2 and force 5 bubbles: required `bubble_cnt_o` holds at 3.
